// File: rtl/lsu_bus_ctrl.sv
// MEM2 load/store bus controller: runs one req/gnt + rvalid transaction per memory op,
// aligning store data and byte enables and returning the raw read word with a done pulse.
package lsu_bus_ctrl_pkg;
    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LBU = 4'd2,
        MEM_LH  = 4'd3,
        MEM_LHU = 4'd4,
        MEM_LW  = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_oper_t;
endpackage

module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  mem_oper_t   req_oper_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        lsu_req_done_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic        lsu_busy_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic req_valid, misaligned, timeout;

    assign req_valid = (req_oper_i != MEM_NOP);
    assign timeout   = (cnt_q == CNT_LAST);

    always_comb begin
        misaligned = 1'b0;
        case (req_oper_i)
            MEM_LW, MEM_SW:          misaligned = (req_addr_i[1:0] != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: misaligned = req_addr_i[0];
            default:                 misaligned = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = misaligned ? S_DONE : S_REQ;
            S_REQ:  if (bus_gnt_i) state_d = bus_rvalid_i ? S_DONE : S_RESP;
            S_RESP: if (bus_rvalid_i || timeout) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; bus fields are only driven while the request is on the bus
    always_comb begin
        bus_req_o      = (state_q == S_REQ);
        bus_we_o       = bus_req_o & we_q;
        bus_addr_o     = bus_req_o ? addr_q  : 32'h0;
        bus_be_o       = bus_req_o ? be_q    : 4'h0;
        bus_wdata_o    = bus_req_o ? wdata_q : 32'h0;
        lsu_busy_o     = (state_q != S_IDLE);
        lsu_req_done_o = (state_q == S_DONE);
        lsu_err_o      = lsu_req_done_o & err_q;
        lsu_rdata_o    = rdata_q;
    end

    // Datapath: request capture, response capture, response timeout counter
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: if (req_valid) begin
                addr_d = {req_addr_i[31:2], 2'b00};
                err_d  = misaligned;
                we_d   = (req_oper_i == MEM_SB) || (req_oper_i == MEM_SH) ||
                         (req_oper_i == MEM_SW);
                case (req_oper_i)
                    MEM_SB: begin
                        be_d    = 4'b0001 << req_addr_i[1:0];
                        wdata_d = {4{req_wdata_i[7:0]}};
                    end
                    MEM_SH: begin
                        be_d    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                        wdata_d = {2{req_wdata_i[15:0]}};
                    end
                    MEM_SW: begin
                        be_d    = 4'hF;
                        wdata_d = req_wdata_i;
                    end
                    default: begin
                        be_d    = 4'hF;
                        wdata_d = 32'h0;
                    end
                endcase
            end
            S_REQ: if (bus_gnt_i && bus_rvalid_i) begin
                rdata_d = we_q ? 32'h0 : bus_rdata_i;
                err_d   = bus_err_i;
            end
            S_RESP: begin
                if (bus_rvalid_i) begin
                    rdata_d = we_q ? 32'h0 : bus_rdata_i;
                    err_d   = bus_err_i;
                end else if (timeout) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed scenarios plus randomized transactions checked
// cycle by cycle against a transaction-level model of the bus handshake.
module tb_lsu_bus_ctrl;
    import lsu_bus_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    mem_oper_t   req_oper_i = MEM_NOP;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic        lsu_req_done_o, lsu_err_o, lsu_busy_o;
    logic [31:0] lsu_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;

    lsu_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_oper_i(req_oper_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .lsu_req_done_o(lsu_req_done_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_err_o(lsu_err_o), .lsu_busy_o(lsu_busy_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int op_size(input mem_oper_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic bit op_store(input mem_oper_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".req"},   32'(bus_req_o), 0);
        chk({tag, ".busy"},  32'(lsu_busy_o), 0);
        chk({tag, ".done"},  32'(lsu_req_done_o), 0);
        chk({tag, ".err"},   32'(lsu_err_o), 0);
        chk({tag, ".we"},    32'(bus_we_o), 0);
        chk({tag, ".addr"},  bus_addr_o, 0);
        chk({tag, ".be"},    32'(bus_be_o), 0);
        chk({tag, ".wdata"}, bus_wdata_o, 0);
        chk({tag, ".rdata"}, lsu_rdata_o, m_rdata);
    endtask

    // g = cycles of gnt held low in REQ; d = cycles from gnt to rvalid (0 = same cycle).
    // d > TO means the response arrives late and must be ignored.
    task automatic txn(input mem_oper_t op, input logic [31:0] addr, input logic [31:0] wd,
                       input int g, input int d, input logic [31:0] rd, input logic berr);
        int          sz, done_c, last, boff;
        bit          mis, st, inreq;
        logic [3:0]  ebe;
        logic [31:0] ewd, eaddr;
        logic        e_err;
        sz    = op_size(op);
        st    = op_store(op);
        mis   = (addr % sz) != 0;
        boff  = int'(addr % 4);
        eaddr = addr - (addr % 4);
        ebe   = st ? 4'(((1 << sz) - 1) << boff) : 4'hF;
        for (int k = 0; k < 4; k++) ewd[8*k +: 8] = st ? wd[8*(k % sz) +: 8] : 8'h00;
        if (mis) begin
            done_c = 1; last = 2; e_err = 1'b1;
        end else begin
            done_c = (d <= TO) ? 2 + g + d : 2 + g + TO;
            e_err  = (d <= TO) ? berr : 1'b1;
            last   = ((1 + g + d) > done_c ? (1 + g + d) : done_c) + 1;
        end
        for (int c = 0; c <= last; c++) begin
            @(posedge clk_i); #1;
            req_oper_i   = (c <= done_c) ? op : MEM_NOP;
            req_addr_i   = (c <= done_c) ? addr : $urandom;
            req_wdata_i  = (c <= done_c) ? wd : $urandom;
            bus_gnt_i    = !mis && (c == 1 + g);
            bus_rvalid_i = !mis && (c == 1 + g + d);
            bus_rdata_i  = bus_rvalid_i ? rd : $urandom;
            bus_err_i    = bus_rvalid_i ? berr : 1'($urandom_range(0, 1));
            @(negedge clk_i);
            if (c == done_c && !mis) m_rdata = (!st && d <= TO) ? rd : 32'h0;
            inreq = !mis && c >= 1 && c <= 1 + g;
            chk("bus_req", 32'(bus_req_o), 32'(inreq));
            chk("busy",    32'(lsu_busy_o), 32'(c >= 1 && c <= done_c));
            chk("done",    32'(lsu_req_done_o), 32'(c == done_c));
            chk("err",     32'(lsu_err_o), (c == done_c) ? 32'(e_err) : 32'h0);
            chk("rdata",   lsu_rdata_o, m_rdata);
            if (inreq) begin
                chk("bus_addr",  bus_addr_o, eaddr);
                chk("bus_be",    32'(bus_be_o), 32'(ebe));
                chk("bus_we",    32'(bus_we_o), 32'(st));
                chk("bus_wdata", bus_wdata_o, ewd);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk_idle_outputs("reset");
        rstn_i = 1'b1;

        // Directed scenarios
        txn(MEM_LW, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1'b0);
        chk("lw.hold", lsu_rdata_o, 32'hDEADBEEF);
        txn(MEM_SB, 32'h203, 32'hA5, 0, 1, 32'h1234_5678, 1'b0);
        txn(MEM_LH, 32'h101, 32'h0, 0, 0, 32'h0, 1'b0);
        txn(MEM_LW, 32'h40, 32'h0, 5, 1, 32'hCAFE_F00D, 1'b0);
        txn(MEM_LW, 32'h44, 32'h0, 0, TO + 2, 32'h5555_AAAA, 1'b0);
        txn(MEM_LHU, 32'h46, 32'h0, 1, 0, 32'h0BAD_0BAD, 1'b0);
        txn(MEM_SH, 32'h82, 32'hBEEF, 2, TO, 32'h0, 1'b1);

        // Reset while waiting for the response
        txn(MEM_LW, 32'h300, 32'h0, 0, 1, 32'h7777_1111, 1'b0);
        @(posedge clk_i); #1;
        req_oper_i = MEM_LW; req_addr_i = 32'h304;
        @(posedge clk_i); #1;
        bus_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        bus_gnt_i = 1'b0;
        #2;
        chk("pre_rst.busy", 32'(lsu_busy_o), 1);
        rstn_i = 1'b0;
        m_rdata = 32'h0;
        #1;
        chk_idle_outputs("async_rst");
        req_oper_i = MEM_NOP;
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            bus_rvalid_i = (c == 0);
            bus_rdata_i  = 32'hFFFF_0000;
            @(negedge clk_i);
            chk("post_rst.done", 32'(lsu_req_done_o), 0);
            chk("post_rst.busy", 32'(lsu_busy_o), 0);
            chk("post_rst.rdata", lsu_rdata_o, 32'h0);
        end
        txn(MEM_LW, 32'h308, 32'h0, 0, 1, 32'h0123_4567, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 250; i++) begin
            mem_oper_t   op;
            logic [31:0] a;
            int          sz;
            op = mem_oper_t'($urandom_range(1, 8));
            sz = op_size(op);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
            txn(op, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 2)),
                $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
